// File: rtl/pack_pkg.sv
// rtl/pack_pkg.sv - shared constants and state encoding for the serial frame packer/transmitter pair
package pack_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFFFFFF7F;
  localparam int          FRAME_BYTES = 16;

  typedef enum logic [1:0] {
    HUNT        = 2'd0,
    RX_FRAME    = 2'd1,
    EXPECT_SYNC = 2'd2
  } packState_t;

  // Sync word byte in arrival order: index 0 is the first byte on the wire.
  function automatic logic [7:0] syncByte(input logic [1:0] idx);
    case (idx)
      2'd0:    syncByte = SYNC_WORD[31:24];
      2'd1:    syncByte = SYNC_WORD[23:16];
      2'd2:    syncByte = SYNC_WORD[15:8];
      default: syncByte = SYNC_WORD[7:0];
    endcase
  endfunction

endpackage

// File: rtl/sync_match.sv
// rtl/sync_match.sv - 4-byte receive history with sync word detection on the incoming byte
module sync_match
  import pack_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byteVal,
  input  logic       byteValid,
  output logic       syncHit
);

  logic [31:0] history;

  // Shift every accepted byte in; newest byte sits in the low byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      history <= '0;
    end else if (byteValid) begin
      history <= {history[23:0], byteVal};
    end
  end

  // Look at the history as it will be after this byte lands, so the lock decision
  // is taken on the same edge that accepts the final sync byte.
  assign syncHit = byteValid && ({history[23:0], byteVal} == SYNC_WORD);

endmodule

// File: rtl/serial_to_pack.sv
// rtl/serial_to_pack.sv - byte stream to 16-byte frame packer with periodic sync; SERIAL_TO_PACK_STATS_EN enables counters
module serial_to_pack
  import pack_pkg::*;
#(
  parameter int SYNC_INTERVAL = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               DataVal,
  input  logic                     DataReady,
  output logic                     DataNext,
  output logic [FRAME_BYTES*8-1:0] Frame,
  output logic                     FrameReady,
  input  logic                     FrameNext,
  output logic                     Locked,
  output logic                     SyncErr,
  output logic [7:0]               OverflowCount,
  output logic [7:0]               SyncErrCount
);

  localparam int              CW      = (SYNC_INTERVAL < 1) ? 1 : $clog2(SYNC_INTERVAL + 1);
  localparam logic [CW-1:0]   CD_INIT = CW'(SYNC_INTERVAL);

  packState_t                 state;
  logic [3:0]                 byteIdx;
  logic [CW-1:0]              countdown;
  logic [FRAME_BYTES*8-1:0]   assembly;
  logic                       frameDone;
  logic                       syncHit;
  logic                       syncMiss;

  sync_match uSyncMatch (
    .clk       (clk),
    .rst       (rst),
    .byteVal   (DataVal),
    .byteValid (DataReady),
    .syncHit   (syncHit)
  );

  assign syncMiss = DataReady && (state == EXPECT_SYNC) && (DataVal != syncByte(byteIdx[1:0]));

  // Receive state machine: hunt for sync, assemble frames, check the periodic sync word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      byteIdx   <= '0;
      countdown <= '0;
      assembly  <= '0;
      frameDone <= 1'b0;
      Locked    <= 1'b0;
      SyncErr   <= 1'b0;
      DataNext  <= 1'b0;
    end else begin
      DataNext  <= 1'b1;
      SyncErr   <= 1'b0;
      frameDone <= 1'b0;
      if (DataReady) begin
        case (state)
          HUNT: begin
            if (syncHit) begin
              state     <= RX_FRAME;
              byteIdx   <= '0;
              countdown <= CD_INIT;
              Locked    <= 1'b1;
            end
          end
          RX_FRAME: begin
            assembly[{byteIdx, 3'b000} +: 8] <= DataVal;
            byteIdx <= byteIdx + 4'd1;
            if (byteIdx == 4'd15) begin
              frameDone <= 1'b1;
              if (countdown == '0) begin
                state <= EXPECT_SYNC;
              end else begin
                countdown <= countdown - 1'b1;
              end
            end
          end
          EXPECT_SYNC: begin
            if (syncMiss) begin
              SyncErr <= 1'b1;
              Locked  <= 1'b0;
              state   <= HUNT;
              byteIdx <= '0;
            end else if (byteIdx == 4'd3) begin
              state     <= RX_FRAME;
              byteIdx   <= '0;
              countdown <= CD_INIT;
            end else begin
              byteIdx <= byteIdx + 4'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // Output frame buffer: a finished frame is published one cycle after its last byte,
  // unless the consumer still holds the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      Frame      <= '0;
      FrameReady <= 1'b0;
    end else if (frameDone && (!FrameReady || FrameNext)) begin
      Frame      <= assembly;
      FrameReady <= 1'b1;
    end else if (FrameReady && FrameNext) begin
      FrameReady <= 1'b0;
    end
  end

`ifdef SERIAL_TO_PACK_STATS_EN
  logic overflowEv;
  assign overflowEv = frameDone && FrameReady && !FrameNext;

  // Saturating statistics counters for dropped frames and sync failures.
  always_ff @(posedge clk) begin
    if (rst) begin
      OverflowCount <= '0;
      SyncErrCount  <= '0;
    end else begin
      if (overflowEv && (OverflowCount != 8'hFF)) begin
        OverflowCount <= OverflowCount + 8'd1;
      end
      if (syncMiss && (SyncErrCount != 8'hFF)) begin
        SyncErrCount <= SyncErrCount + 8'd1;
      end
    end
  end
`else
  assign OverflowCount = '0;
  assign SyncErrCount  = '0;
`endif

endmodule

// File: doc/serial_to_pack.md
SERIAL_TO_PACK -- requirements
Module: serial_to_pack

Interface
REQ-001 SHALL have parameter SYNC_INTERVAL, default 15, meaning the number of frames between consecutive sync words minus one (a sync word precedes every (SYNC_INTERVAL+1)th frame).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port DataVal  input  8  received byte.
REQ-005 SHALL have port DataReady  input  1  single-cycle strobe; DataVal is valid this cycle.
REQ-006 SHALL have port DataNext  output  1  byte-accept indication; 0 in reset, 1 otherwise.
REQ-007 SHALL have port Frame  output  128  assembled frame; byte k of the frame occupies bits [8k+7:8k].
REQ-008 SHALL have port FrameReady  output  1  Frame holds an unconsumed frame.
REQ-009 SHALL have port FrameNext  input  1  single-cycle consumer acknowledge for the current frame.
REQ-010 SHALL have port Locked  output  1  sync acquired; frames are being assembled.
REQ-011 SHALL have port SyncErr  output  1  one-cycle pulse when an expected sync word mismatches.
REQ-012 SHALL have ports OverflowCount and SyncErrCount  output  8 each  statistics (see REQ-027).

Function
REQ-013 SHALL sample a byte only in a cycle where DataReady=1; bytes with DataReady=0 are ignored.
REQ-014 SHALL shift every accepted byte, in all states, into a 4-byte history register; sync word = FF,FF,FF,7F in arrival order.
REQ-015 SHALL implement states HUNT, RX_FRAME, EXPECT_SYNC.
REQ-016 In HUNT, when the history register equals the sync word after an update, SHALL enter RX_FRAME with byte index 0 and frame countdown = SYNC_INTERVAL, and set Locked=1.
REQ-017 In RX_FRAME, SHALL write accepted byte k into assembly register bits [8k+7:8k], k from 0 to 15.
REQ-018 On byte 15, if the countdown is 0, SHALL enter EXPECT_SYNC; otherwise SHALL decrement the countdown and remain in RX_FRAME with index 0.
REQ-019 In EXPECT_SYNC, SHALL compare 4 accepted bytes against the sync word in order; on a full match, SHALL enter RX_FRAME with countdown = SYNC_INTERVAL.
REQ-020 On the first mismatching byte in EXPECT_SYNC, SHALL pulse SyncErr, clear Locked and enter HUNT; hunting continues from the current history contents.
REQ-021 On completion of byte 15, SHALL present the frame, with FrameReady=1 on the following edge (1-cycle latency).
REQ-022 SHALL hold Frame and FrameReady stable until FrameNext=1; FrameNext with FrameReady=0 SHALL be ignored.
REQ-023 If completion and FrameNext coincide, SHALL load the new frame and keep FrameReady=1.
REQ-024 If completion occurs while FrameReady=1 and FrameNext=0, SHALL drop the new frame, keep the old frame and count an overflow.
REQ-025 Overlapping sync patterns (e.g. FF,FF,FF,FF,7F) SHALL lock on the 7F byte; the next accepted byte is frame byte 0.

Reset
REQ-026 On rst=1 at a clock edge, SHALL enter HUNT, clear the history, index, countdown and assembly register, and set Frame=0, FrameReady=0, Locked=0, SyncErr=0, DataNext=0 and both counters to 0; any partial frame is discarded.

Configuration
REQ-027 With SERIAL_TO_PACK_STATS_EN defined, SHALL drive OverflowCount (incremented per REQ-024) and SyncErrCount (incremented per SyncErr pulse) as 8-bit counters saturating at 255; without it, both ports SHALL be tied to 0 and the counters omitted.

Structure
REQ-028 Package pack_pkg SHALL hold SYNC_WORD (32'hFFFFFF7F), FRAME_BYTES (16) and the state enum shared with the transmitter.
REQ-029 SHALL instantiate one sub-module, sync_match, containing the 4-byte history register and its comparator.

Verification
REQ-030 Reset, then bytes FF,FF,FF,7F,00..0F -> Locked=1 after the 7F; FrameReady=1 one cycle after byte 0F; Frame=128'h0F0E..0100.
REQ-031 Locked stream with SYNC_INTERVAL=1: sync, 2 frames, then bytes FF,FF,FE -> SyncErr pulses on the FE, Locked=0 and the state is HUNT.
REQ-032 Two complete frames with FrameNext held 0 -> first frame retained, second dropped, OverflowCount=1 (macro defined) or 0 (macro undefined).
REQ-033 FF,FF,FF,FF,7F then 16 bytes AA -> lock on the 7F; Frame is all AA.
REQ-034 rst asserted after frame byte 7 -> FrameReady=0, Locked=0; a fresh sync and 16 bytes yield a correct frame.
REQ-035 Frame completion in the same cycle as FrameNext=1 -> FrameReady stays 1 and Frame updates to the new value.
